// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the small sigma functions used by schedule and compression.
package sha256_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BLOCK_W        = 512;
  localparam int unsigned WINDOW         = BLOCK_W / WORD_W;
  localparam int unsigned ROUNDS_DEFAULT = 64;

  // Rotate/shift amounts for the message-schedule sigma functions
  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;

  // Rotate right by a constant amount in 1..WORD_W-1
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Control/data bundle between the control unit and the message scheduler.
interface sha256_msg_schedule_if
  import sha256_pkg::*;
#(
  parameter int unsigned RND_W = 6
);

  logic               i_load;
  logic [BLOCK_W-1:0] i_block;
  logic               i_cnt_en;
  word_t              o_w;
  logic [RND_W-1:0]   o_round;
  logic               o_valid;
  logic               o_last;

  modport master (
    output i_load, i_block, i_cnt_en,
    input  o_w, o_round, o_valid, o_last
  );

  modport slave (
    input  i_load, i_block, i_cnt_en,
    output o_w, o_round, o_valid, o_last
  );

endinterface

// File: rtl/sha256_w_next.sv
// Combinational W_{t+16} from the four window taps it depends on.
module sha256_w_next
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w16_c
);

  // Modular 32-bit sum; carries fall off the top
  assign w16_c = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16-word sliding window producing one W_t per enabled cycle.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
  parameter int unsigned RND_W  = 6
)(
  input logic                  clk,
  input logic                  reset_n,
  sha256_msg_schedule_if.slave bus
);

  typedef logic [WINDOW-1:0][WORD_W-1:0] window_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  window_t          win_q, win_n;
  logic [RND_W-1:0] round_q, round_n;
  logic             valid_q, valid_n;
  logic             last_q, last_n;
  word_t            w16_c;

  sha256_w_next u_w_next (
    .w0    (win_q[0]),
    .w1    (win_q[1]),
    .w9    (win_q[9]),
    .w14   (win_q[14]),
    .w16_c (w16_c)
  );

  // Next-state: load beats everything; advance, saturate, hold or abort otherwise
  always_comb begin
    win_n   = win_q;
    round_n = round_q;
    valid_n = valid_q;

    if (bus.i_load) begin
      for (int k = 0; k < WINDOW; k++) begin
        win_n[k] = bus.i_block[BLOCK_W - 1 - k * WORD_W -: WORD_W];
      end
      round_n = '0;
      valid_n = 1'b1;
    end else if (valid_q) begin
      if (bus.i_cnt_en) begin
        // At the last round the window and index saturate, like the counter
        if (round_q != LAST_RND) begin
          for (int k = 0; k < WINDOW - 1; k++) begin
            win_n[k] = win_q[k + 1];
          end
          win_n[WINDOW - 1] = w16_c;
          round_n           = round_q + RND_W'(1);
        end
      end else if (round_q != '0) begin
        // Enable dropped after advancing: block ends, counter has cleared
        valid_n = 1'b0;
        round_n = '0;
      end
    end

    // Registered flag computed from next state so it lines up with o_round
    last_n = valid_n && (round_n == LAST_RND);
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      win_q   <= win_n;
      round_q <= round_n;
      valid_q <= valid_n;
      last_q  <= last_n;
    end
  end

  assign bus.o_w     = win_q[0];
  assign bus.o_round = round_q;
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for the SHA-256 message scheduler.
module tb_sha256_msg_schedule;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   cnt;
  logic [31:0] exp_w [64];

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] FF_BLK  = {512{1'b1}};

  sha256_msg_schedule_if #(.RND_W(6)) bus ();

  sha256_msg_schedule #(.ROUNDS(64), .RND_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference round counter sharing the enable: saturates at 63, clears when disabled
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt <= 0;
    else if (bus.i_load)   cnt <= 0;
    else if (bus.i_cnt_en) cnt <= (cnt == 63) ? 63 : cnt + 1;
    else                   cnt <= 0;
  end

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook 64-entry expansion, independent of the sliding window
  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [511:0] blk, input logic en);
    bus.i_block  = blk;
    bus.i_load   = 1'b1;
    bus.i_cnt_en = en;
    step();
    bus.i_load   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.i_load   = 1'b0;
    bus.i_cnt_en = 1'b0;
    bus.i_block  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.o_w !== 32'h0) begin errors++; $display("FAIL reset_w cyc=%0d got %h want 0", i, bus.o_w); end
      checks++;
      if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc=%0d got %b want 0", i, bus.o_valid); end
      checks++;
      if (bus.o_round !== 6'd0) begin errors++; $display("FAIL reset_round cyc=%0d got %0d want 0", i, bus.o_round); end
      checks++;
      if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_last cyc=%0d got %b want 0", i, bus.o_last); end
    end
  endtask

  task automatic test_abc();
    build_model(ABC_BLK);
    load_block(ABC_BLK, 1'b0);
    checks++;
    if (bus.o_w !== 32'h61626380) begin errors++; $display("FAIL abc_w0 got %h want 61626380", bus.o_w); end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_round !== 6'd0 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL abc_load_state got v=%b r=%0d l=%b want v=1 r=0 l=0", bus.o_valid, bus.o_round, bus.o_last);
    end
    bus.i_cnt_en = 1'b1;
    for (int t = 1; t < 64; t++) begin
      step();
      checks++;
      if (bus.o_w !== exp_w[t]) begin errors++; $display("FAIL abc_w t=%0d got %h want %h", t, bus.o_w, exp_w[t]); end
      checks++;
      if (int'(bus.o_round) !== t || int'(bus.o_round) !== cnt) begin
        errors++; $display("FAIL abc_round t=%0d got %0d want %0d (counter %0d)", t, bus.o_round, t, cnt);
      end
      checks++;
      if (bus.o_last !== (t == 63)) begin errors++; $display("FAIL abc_last t=%0d got %b want %b", t, bus.o_last, (t == 63)); end
      if (t == 15) begin
        checks++;
        if (bus.o_w !== 32'h00000018) begin errors++; $display("FAIL abc_w15 got %h want 00000018", bus.o_w); end
      end
      if (t == 16) begin
        checks++;
        if (bus.o_w !== 32'h61626380) begin errors++; $display("FAIL abc_w16 got %h want 61626380", bus.o_w); end
      end
      if (t == 17) begin
        checks++;
        if (bus.o_w !== 32'h000F0000) begin errors++; $display("FAIL abc_w17 got %h want 000f0000", bus.o_w); end
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.o_round !== 6'd63 || bus.o_last !== 1'b1 || bus.o_valid !== 1'b1) begin
        errors++; $display("FAIL sat_state i=%0d got r=%0d l=%b v=%b want r=63 l=1 v=1", i, bus.o_round, bus.o_last, bus.o_valid);
      end
      checks++;
      if (bus.o_w !== exp_w[63]) begin errors++; $display("FAIL sat_w i=%0d got %h want %h", i, bus.o_w, exp_w[63]); end
    end
    bus.i_cnt_en = 1'b0;
    step();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL sat_end got v=%b l=%b want v=0 l=0", bus.o_valid, bus.o_last);
    end
  endtask

  task automatic test_abort();
    build_model(ABC_BLK);
    load_block(ABC_BLK, 1'b0);
    // Enable held low right after load: everything holds
    step();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_round !== 6'd0 || bus.o_w !== exp_w[0]) begin
      errors++; $display("FAIL hold_r0 got v=%b r=%0d w=%h want v=1 r=0 w=%h", bus.o_valid, bus.o_round, bus.o_w, exp_w[0]);
    end
    bus.i_cnt_en = 1'b1;
    repeat (20) step();
    checks++;
    if (bus.o_round !== 6'd20 || bus.o_w !== exp_w[20]) begin
      errors++; $display("FAIL abort_pre got r=%0d w=%h want r=20 w=%h", bus.o_round, bus.o_w, exp_w[20]);
    end
    bus.i_cnt_en = 1'b0;
    step();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_round !== 6'd0 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL abort_state got v=%b r=%0d l=%b want v=0 r=0 l=0", bus.o_valid, bus.o_round, bus.o_last);
    end
    checks++;
    if (bus.o_w !== exp_w[20]) begin errors++; $display("FAIL abort_w got %h want %h", bus.o_w, exp_w[20]); end
    bus.i_cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_round !== 6'd0 || bus.o_w !== exp_w[20]) begin
        errors++; $display("FAIL abort_idle i=%0d got v=%b r=%0d w=%h want v=0 r=0 w=%h", i, bus.o_valid, bus.o_round, bus.o_w, exp_w[20]);
      end
    end
    bus.i_cnt_en = 1'b0;
  endtask

  task automatic test_load_collision();
    load_block(ABC_BLK, 1'b0);
    bus.i_cnt_en = 1'b1;
    repeat (30) step();
    checks++;
    if (bus.o_round !== 6'd30) begin errors++; $display("FAIL coll_pre got r=%0d want 30", bus.o_round); end
    build_model(FF_BLK);
    load_block(FF_BLK, 1'b1);
    checks++;
    if (bus.o_round !== 6'd0 || bus.o_w !== 32'hFFFFFFFF || bus.o_valid !== 1'b1) begin
      errors++; $display("FAIL coll_load got r=%0d w=%h v=%b want r=0 w=ffffffff v=1", bus.o_round, bus.o_w, bus.o_valid);
    end
    for (int t = 1; t <= 16; t++) begin
      step();
      checks++;
      if (bus.o_w !== exp_w[t] || int'(bus.o_round) !== t) begin
        errors++; $display("FAIL coll_w t=%0d got w=%h r=%0d want w=%h r=%0d", t, bus.o_w, bus.o_round, exp_w[t], t);
      end
      // sigma0(~0)=1fffffff, sigma1(~0)=003fffff, plus two all-ones words (-2)
      if (t == 16) begin
        checks++;
        if (bus.o_w !== 32'h203FFFFC) begin errors++; $display("FAIL coll_w16 got %h want 203ffffc", bus.o_w); end
      end
    end
    bus.i_cnt_en = 1'b0;
  endtask

  task automatic test_async_reset();
    build_model(ABC_BLK);
    load_block(ABC_BLK, 1'b0);
    bus.i_cnt_en = 1'b1;
    repeat (40) step();
    checks++;
    if (bus.o_round !== 6'd40 || bus.o_w !== exp_w[40]) begin
      errors++; $display("FAIL areset_pre got r=%0d w=%h want r=40 w=%h", bus.o_round, bus.o_w, exp_w[40]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.o_round !== 6'd0 || bus.o_w !== 32'h0) begin
      errors++; $display("FAIL areset_now got v=%b l=%b r=%0d w=%h want all 0", bus.o_valid, bus.o_last, bus.o_round, bus.o_w);
    end
    bus.i_cnt_en = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_round !== 6'd0 || bus.o_w !== 32'h0) begin
      errors++; $display("FAIL areset_after got v=%b r=%0d w=%h want all 0", bus.o_valid, bus.o_round, bus.o_w);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_abc();
    test_saturation();
    test_abort();
    test_load_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
